// File: rtl/incubator_pkg.sv
// Shared definitions for the incubator plant model and its controller:
// widths, temperature limits, controller thresholds and the clamp helper.
package incubator_pkg;

  localparam int TEMP_W     = 8;
  localparam int RPS_W      = 4;
  localparam int T_INIT_DEF = 25;
  localparam int T_MIN_DEF  = -40;
  localparam int T_MAX_DEF  = 100;

  // Controller thresholds, kept here so controller and plant agree.
  localparam int TH_COLD  = 15;
  localparam int TH_LOW   = 25;
  localparam int TH_SET   = 30;
  localparam int TH_WARM  = 35;
  localparam int TH_HOT   = 40;
  localparam int TH_ALARM = 45;

  // What the plant does to t on the current edge.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_CONFLICT,
    ACT_HEAT,
    ACT_COOL,
    ACT_DRIFT_MOVE,
    ACT_DRIFT_COUNT
  } plant_act_e;

  // Saturate a 10-bit intermediate to [lo,hi] and return it as an 8-bit temperature.
  function automatic logic signed [TEMP_W-1:0] clamp_temp(
    input logic signed [9:0] v,
    input logic signed [9:0] lo,
    input logic signed [9:0] hi
  );
    logic signed [9:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r[TEMP_W-1:0];
  endfunction

endpackage

// File: rtl/incubator_tick_gen.sv
// Prescaler for the thermal model: one-cycle tick every TICK_DIV clocks,
// decoded from the counter register.
module incubator_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Free-running counter 0..TICK_DIV-1, wraps on the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/incubator_plant.sv
// Synthesizable thermal model of the incubator chamber. Integrates heater,
// cooler/fan and ambient drift once per tick and reports a clamped signed
// temperature plus saturation and heater/cooler conflict flags.
module incubator_plant
  import incubator_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int HEAT_STEP = 2,
  parameter int COOL_BASE = 1,
  parameter int DRIFT_DIV = 3,
  parameter int T_INIT    = T_INIT_DEF,
  parameter int T_MIN     = T_MIN_DEF,
  parameter int T_MAX     = T_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_heater,
  input  logic                     i_cooler,
  input  logic [RPS_W-1:0]         i_rps,
  input  logic signed [TEMP_W-1:0] i_ambient,
  input  logic                     i_load,
  input  logic signed [TEMP_W-1:0] i_load_val,
  output logic signed [TEMP_W-1:0] o_t,
  output logic                     o_tick,
  output logic                     o_sat_hi,
  output logic                     o_sat_lo,
  output logic                     o_conflict
);

  localparam int DW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;
  localparam logic [DW-1:0] DRIFT_LAST = DW'(DRIFT_DIV - 1);

  // All arithmetic is done in 10 bits so no sum can wrap before clamping.
  localparam logic signed [9:0] L_MIN10  = 10'(T_MIN);
  localparam logic signed [9:0] L_MAX10  = 10'(T_MAX);
  localparam logic signed [9:0] L_HEAT10 = 10'(HEAT_STEP);
  localparam logic signed [9:0] L_COOL10 = 10'(COOL_BASE);
  localparam logic signed [TEMP_W-1:0] L_MIN8  = TEMP_W'(T_MIN);
  localparam logic signed [TEMP_W-1:0] L_MAX8  = TEMP_W'(T_MAX);
  localparam logic signed [TEMP_W-1:0] L_INIT8 = TEMP_W'(T_INIT);

  logic w_tick;

  logic signed [TEMP_W-1:0] r_t;
  logic [DW-1:0]            r_drift;
  logic                     r_sat_hi;
  logic                     r_sat_lo;
  logic                     r_conflict;

  plant_act_e               w_act;
  logic signed [9:0]        w_t_ext;
  logic signed [9:0]        w_load_ext;
  logic signed [9:0]        w_cool_step;
  logic signed [9:0]        w_sum;
  logic signed [TEMP_W-1:0] w_t_next;
  logic [DW-1:0]            w_drift_next;

  incubator_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (w_tick)
  );

  assign w_t_ext     = {{(10-TEMP_W){r_t[TEMP_W-1]}}, r_t};
  assign w_load_ext  = {{(10-TEMP_W){i_load_val[TEMP_W-1]}}, i_load_val};
  // Fan contribution is rps>>1 on top of the base cooling step.
  assign w_cool_step = L_COOL10 + $signed({{(11-RPS_W){1'b0}}, i_rps[RPS_W-1:1]});

  // Pick the edge's action: load on any edge, actuators/drift only on tick edges.
  always_comb begin
    w_act = ACT_HOLD;
    if (i_load) begin
      w_act = ACT_LOAD;
    end else if (w_tick) begin
      if (i_heater && i_cooler) w_act = ACT_CONFLICT;
      else if (i_heater) w_act = ACT_HEAT;
      else if (i_cooler) w_act = ACT_COOL;
      else if (r_drift == DRIFT_LAST) w_act = ACT_DRIFT_MOVE;
      else w_act = ACT_DRIFT_COUNT;
    end
  end

  // Next temperature (unclamped) and next drift count for the chosen action.
  always_comb begin
    w_sum        = w_t_ext;
    w_drift_next = r_drift;
    case (w_act)
      ACT_LOAD: begin
        w_sum        = w_load_ext;
        w_drift_next = '0;
      end
      ACT_CONFLICT: begin
        w_drift_next = '0;
      end
      ACT_HEAT: begin
        w_sum        = w_t_ext + L_HEAT10;
        w_drift_next = '0;
      end
      ACT_COOL: begin
        w_sum        = w_t_ext - w_cool_step;
        w_drift_next = '0;
      end
      ACT_DRIFT_MOVE: begin
        w_drift_next = '0;
        if (r_t < i_ambient) w_sum = w_t_ext + 10'sd1;
        else if (r_t > i_ambient) w_sum = w_t_ext - 10'sd1;
      end
      ACT_DRIFT_COUNT: begin
        w_drift_next = r_drift + 1'b1;
      end
      default: begin
        w_sum        = w_t_ext;
        w_drift_next = r_drift;
      end
    endcase
  end

  assign w_t_next = clamp_temp(w_sum, L_MIN10, L_MAX10);

  // Temperature, drift counter and flags; flags follow the new temperature.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t        <= L_INIT8;
      r_drift    <= '0;
      r_sat_hi   <= 1'b0;
      r_sat_lo   <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_t      <= w_t_next;
      r_drift  <= w_drift_next;
      r_sat_hi <= (w_t_next == L_MAX8);
      r_sat_lo <= (w_t_next == L_MIN8);
      if (w_act == ACT_CONFLICT) r_conflict <= 1'b1;
    end
  end

  assign o_t        = r_t;
  assign o_tick     = w_tick;
  assign o_sat_hi   = r_sat_hi;
  assign o_sat_lo   = r_sat_lo;
  assign o_conflict = r_conflict;

endmodule

// File: tb/tb_incubator_plant.sv
// Directed bench for incubator_plant: reset/prescaler timing, heating, cooling
// with fan, ambient drift, clamping, conflict, pulse rejection, async reset and
// a small closed loop with a bang-bang controller in the bench.
module tb_incubator_plant;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_heater;
  logic              i_cooler;
  logic [3:0]        i_rps;
  logic signed [7:0] i_ambient;
  logic              i_load;
  logic signed [7:0] i_load_val;
  logic signed [7:0] o_t;
  logic              o_tick;
  logic              o_sat_hi;
  logic              o_sat_lo;
  logic              o_conflict;

  int n_checks = 0;
  int n_errors = 0;

  incubator_plant dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_heater  (i_heater),
    .i_cooler  (i_cooler),
    .i_rps     (i_rps),
    .i_ambient (i_ambient),
    .i_load    (i_load),
    .i_load_val(i_load_val),
    .o_t       (o_t),
    .o_tick    (o_tick),
    .o_sat_hi  (o_sat_hi),
    .o_sat_lo  (o_sat_lo),
    .o_conflict(o_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance to the negedge just after the next tick edge (bounded wait).
  task automatic tick_update();
    int waited;
    waited = 0;
    while (o_tick !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (o_tick !== 1'b1) check("tick_wait", int'(o_tick), 1);
    @(negedge clk);
  endtask

  task automatic load_temp(input int v);
    i_load     = 1'b1;
    i_load_val = 8'(v);
    @(negedge clk);
    i_load     = 1'b0;
  endtask

  initial begin
    int  ctrl_heat;
    int  seen_hi;
    int  reengaged;
    int  peak;
    int  t_at_reengage;

    rst_n      = 1'b0;
    i_heater   = 1'b1;
    i_cooler   = 1'b0;
    i_rps      = 4'd0;
    i_ambient  = 8'sd25;
    i_load     = 1'b0;
    i_load_val = 8'sd0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_t", int'(o_t), 25);
    check("rst_tick", int'(o_tick), 0);
    check("rst_sat_hi", int'(o_sat_hi), 0);
    check("rst_sat_lo", int'(o_sat_lo), 0);
    check("rst_conflict", int'(o_conflict), 0);

    // Prescaler timing and heating: t changes on the 4th edge after release
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("tick_edge2", int'(o_tick), 0);
    @(negedge clk);
    check("tick_edge3", int'(o_tick), 1);
    check("t_before_tick", int'(o_t), 25);
    @(negedge clk);
    check("heat_first", int'(o_t), 27);
    check("tick_after", int'(o_tick), 0);
    repeat (3) @(negedge clk);
    check("tick_period", int'(o_tick), 1);
    check("t_hold_between", int'(o_t), 27);
    @(negedge clk);
    check("heat_second", int'(o_t), 29);

    // Load, then cooling with fan
    i_heater = 1'b0;
    load_temp(40);
    check("load_40", int'(o_t), 40);
    i_cooler = 1'b1;
    i_rps    = 4'd8;
    tick_update();
    check("cool_rps8", int'(o_t), 35);
    i_rps = 4'd0;
    tick_update();
    check("cool_rps0", int'(o_t), 34);
    i_rps = 4'd6;
    tick_update();
    check("cool_rps6", int'(o_t), 30);
    i_cooler = 1'b0;
    i_rps    = 4'd0;

    // Drift toward ambient every third idle tick
    i_ambient = 8'sd20;
    load_temp(25);
    tick_update();
    tick_update();
    check("drift_tick2", int'(o_t), 25);
    tick_update();
    check("drift_tick3", int'(o_t), 24);
    repeat (3) tick_update();
    check("drift_tick6", int'(o_t), 23);
    i_ambient = 8'sd23;
    repeat (6) tick_update();
    check("drift_at_ambient", int'(o_t), 23);
    i_ambient = 8'sd30;
    load_temp(28);
    repeat (3) tick_update();
    check("drift_up", int'(o_t), 29);

    // Upper clamp
    load_temp(99);
    i_heater = 1'b1;
    tick_update();
    check("clamp_hi", int'(o_t), 100);
    check("sat_hi_set", int'(o_sat_hi), 1);
    tick_update();
    check("clamp_hi_hold", int'(o_t), 100);
    i_heater = 1'b0;

    // Lower clamp
    load_temp(-39);
    check("load_m39", int'(o_t), -39);
    check("sat_hi_clear", int'(o_sat_hi), 0);
    check("sat_lo_before", int'(o_sat_lo), 0);
    i_cooler = 1'b1;
    i_rps    = 4'd8;
    tick_update();
    check("clamp_lo", int'(o_t), -40);
    check("sat_lo_set", int'(o_sat_lo), 1);
    i_cooler = 1'b0;
    i_rps    = 4'd0;

    // Load value clamping
    load_temp(120);
    check("load_120", int'(o_t), 100);
    check("load_120_sat", int'(o_sat_hi), 1);
    check("load_120_satlo", int'(o_sat_lo), 0);
    load_temp(-128);
    check("load_m128", int'(o_t), -40);

    // Actuator pulses between ticks are ignored
    i_ambient = 8'sd60;
    load_temp(60);
    tick_update();
    i_heater = 1'b1;
    i_cooler = 1'b1;
    repeat (2) @(negedge clk);
    i_heater = 1'b0;
    i_cooler = 1'b0;
    tick_update();
    check("pulse_ignored_t", int'(o_t), 60);
    check("pulse_no_conflict", int'(o_conflict), 0);

    // Conflict: t unchanged, flag sticky
    load_temp(50);
    i_heater = 1'b1;
    i_cooler = 1'b1;
    tick_update();
    check("conflict_t", int'(o_t), 50);
    check("conflict_set", int'(o_conflict), 1);
    i_heater = 1'b0;
    i_cooler = 1'b0;
    repeat (2) tick_update();
    check("conflict_sticky", int'(o_conflict), 1);

    // Async reset mid-ramp
    load_temp(31);
    i_heater = 1'b1;
    tick_update();
    check("ramp_33", int'(o_t), 33);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_t", int'(o_t), 25);
    check("async_rst_conflict", int'(o_conflict), 0);
    check("async_rst_tick", int'(o_tick), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_tick_edge2", int'(o_tick), 0);
    @(negedge clk);
    check("rst2_tick_edge3", int'(o_tick), 1);
    @(negedge clk);
    check("rst2_heat", int'(o_t), 27);

    // Closed loop with a bang-bang controller (on below 15, off above 30)
    i_ambient     = 8'sd10;
    i_heater      = 1'b0;
    load_temp(10);
    ctrl_heat     = 1;
    seen_hi       = 0;
    reengaged     = 0;
    peak          = -128;
    t_at_reengage = 0;
    for (int cyc = 0; cyc < 2000 && reengaged == 0; cyc++) begin
      if (int'(o_t) > peak) peak = int'(o_t);
      if (int'(o_t) > 30) seen_hi = 1;
      if (int'(o_t) < 15) begin
        if (ctrl_heat == 0 && seen_hi == 1) begin
          reengaged     = 1;
          t_at_reengage = int'(o_t);
        end
        ctrl_heat = 1;
      end else if (int'(o_t) > 30) begin
        ctrl_heat = 0;
      end
      i_heater = (ctrl_heat != 0);
      @(negedge clk);
    end
    check("loop_seen_hi", seen_hi, 1);
    check("loop_peak", peak, 32);
    check("loop_reengaged", reengaged, 1);
    check("loop_reengage_t", t_at_reengage, 14);
    check("loop_no_conflict", int'(o_conflict), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
